// File: rtl/captura_jogada_if.sv
// Move-entry bus between the square-selection front end and the game controller.
// The controller drives the master side; captura_jogada sits on the slave side.
interface captura_jogada_if;
    logic        habilita;
    logic        botao;
    logic [5:0]  casa;
    logic        cancelar;
    logic        consumido;
    logic [11:0] jogada;
    logic        temJogada;
    logic        aguardando_destino;
    logic        erro;
    logic [2:0]  db_estado;

    modport master (
        output habilita, botao, casa, cancelar, consumido,
        input  jogada, temJogada, aguardando_destino, erro, db_estado
    );

    modport slave (
        input  habilita, botao, casa, cancelar, consumido,
        output jogada, temJogada, aguardando_destino, erro, db_estado
    );
endinterface

// File: rtl/captura_jogada.sv
// Captures a chess move as two square presses (origin, destination) and holds the
// completed move until the controller acknowledges it.
module captura_jogada #(
    parameter int TIMEOUT_CICLOS = 1000
) (
    input logic             clock,
    input logic             reset,
    captura_jogada_if.slave bus
);
    localparam logic [2:0] DESAB   = 3'd0;
    localparam logic [2:0] ORIGEM  = 3'd1;
    localparam logic [2:0] DESTINO = 3'd2;
    localparam logic [2:0] ERRO    = 3'd3;
    localparam logic [2:0] PRONTA  = 3'd4;

    localparam logic [15:0] TIMEOUT_FIM = 16'(TIMEOUT_CICLOS - 1);

    logic [2:0]  estado;
    logic [2:0]  estadoProx;
    logic        botaoD;
    logic        pressao;
    logic [5:0]  origemReg;
    logic [11:0] jogadaReg;
    logic [15:0] timerReg;
    logic        latchOrigem;
    logic        latchDestino;
    logic        incTimer;

    assign pressao = bus.botao & ~botaoD;

    always_comb begin
        estadoProx   = estado;
        latchOrigem  = 1'b0;
        latchDestino = 1'b0;
        incTimer     = 1'b0;
        case (estado)
            DESAB: begin
                if (bus.habilita) estadoProx = ORIGEM;
            end
            ORIGEM: begin
                if (!bus.habilita) begin
                    estadoProx = DESAB;
                end else if (pressao) begin
                    latchOrigem = 1'b1;
                    estadoProx  = DESTINO;
                end
            end
            DESTINO: begin
                if (!bus.habilita) begin
                    estadoProx = DESAB;
                end else if (bus.cancelar || timerReg == TIMEOUT_FIM) begin
                    estadoProx = ORIGEM;
                end else if (pressao) begin
                    if (bus.casa == origemReg) begin
                        estadoProx = ERRO;
                    end else begin
                        latchDestino = 1'b1;
                        estadoProx   = PRONTA;
                    end
                end else begin
                    incTimer = 1'b1;
                end
            end
            ERRO: begin
                estadoProx = ORIGEM;
            end
            PRONTA: begin
                // Only the acknowledge can leave here, so a pending move is never lost.
                if (bus.consumido) estadoProx = bus.habilita ? ORIGEM : DESAB;
            end
            default: begin
                estadoProx = DESAB;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado    <= DESAB;
            botaoD    <= 1'b0;
            origemReg <= 6'd0;
            jogadaReg <= 12'd0;
            timerReg  <= 16'd0;
        end else begin
            estado <= estadoProx;
            botaoD <= bus.botao;
            if (latchOrigem) origemReg <= bus.casa;
            // Low half of jogadaReg doubles as the destination register.
            if (latchDestino) jogadaReg <= {origemReg, bus.casa};
            if (latchOrigem) begin
                timerReg <= 16'd0;
            end else if (incTimer) begin
                timerReg <= timerReg + 16'd1;
            end
        end
    end

    assign bus.jogada             = jogadaReg;
    assign bus.temJogada          = (estado == PRONTA);
    assign bus.aguardando_destino = (estado == DESTINO);
    assign bus.erro               = (estado == ERRO);
    assign bus.db_estado          = estado;
endmodule
